// File: rtl/qlf_k6n10_seq_alu_if.sv
// Request/result handshake bundle for the sequential segmented ALU.
interface qlf_k6n10_seq_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             bi;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] co;

  // Requester / result consumer side
  modport master (
    output in_valid, a, b, ci, bi, out_ready,
    input  in_ready, out_valid, y, x, co
  );

  // ALU side
  modport slave (
    input  in_valid, a, b, ci, bi, out_ready,
    output in_ready, out_valid, y, x, co
  );
endinterface

// File: rtl/qlf_k6n10_seq_alu.sv
// Multi-cycle $alu: one SEG-bit carry-chain segment per clock, inter-segment
// carry kept in a register, valid/ready on both request and result sides.
module qlf_k6n10_seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  qlf_k6n10_seq_alu_if.slave   bus
);

  localparam int unsigned NSEG  = WIDTH / SEG;
  localparam int unsigned SEG_W = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] aa_q, aa_d;
  logic [WIDTH-1:0] bb_q, bb_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] co_q, co_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  int unsigned      base;
  logic [SEG-1:0]   seg_a;
  logic [SEG-1:0]   seg_b;
  logic [SEG-1:0]   seg_s;
  logic [SEG-1:0]   seg_co;
  logic             rc;
  logic             seg_cout;

  assign bus.in_ready  = (state_q == IDLE) && resetn;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.x         = x_q;
  assign bus.co        = co_q;

  // Ripple carry across the active segment, seeded by the held carry
  always_comb begin
    base   = 32'(seg_q) * SEG;
    seg_a  = aa_q[base +: SEG];
    seg_b  = bb_q[base +: SEG];
    seg_s  = '0;
    seg_co = '0;
    rc     = carry_q;
    for (int unsigned i = 0; i < SEG; i++) begin
      seg_s[i]  = seg_a[i] ^ seg_b[i] ^ rc;
      rc        = (seg_a[i] & seg_b[i]) | (rc & (seg_a[i] ^ seg_b[i]));
      seg_co[i] = rc;
    end
    seg_cout = rc;
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    carry_d     = carry_q;
    aa_d        = aa_q;
    bb_d        = bb_q;
    y_d         = y_q;
    x_d         = x_q;
    co_d        = co_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          aa_d    = bus.a;
          bb_d    = bus.bi ? ~bus.b : bus.b;
          carry_d = bus.ci;
          seg_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        y_d[base +: SEG]  = seg_s;
        x_d[base +: SEG]  = seg_a ^ seg_b;
        co_d[base +: SEG] = seg_co;
        carry_d           = seg_cout;
        if (seg_q == SEG_W'(NSEG - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          seg_d = seg_q + SEG_W'(1);
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      seg_q       <= '0;
      carry_q     <= 1'b0;
      aa_q        <= '0;
      bb_q        <= '0;
      y_q         <= '0;
      x_q         <= '0;
      co_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      carry_q     <= carry_d;
      aa_q        <= aa_d;
      bb_q        <= bb_d;
      y_q         <= y_d;
      x_q         <= x_d;
      co_q        <= co_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_qlf_k6n10_seq_alu.sv
// Directed-vector bench for qlf_k6n10_seq_alu (32/8 and 8/8 configurations).
module tb_qlf_k6n10_seq_alu;

  logic clk;
  logic resetn;
  int   n_vec;
  int   n_err;

  qlf_k6n10_seq_alu_if #(.WIDTH(32)) bus32 ();
  qlf_k6n10_seq_alu_if #(.WIDTH(8))  bus8 ();

  qlf_k6n10_seq_alu #(.WIDTH(32), .SEG(8)) u_dut32 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus32)
  );

  qlf_k6n10_seq_alu #(.WIDTH(8), .SEG(8)) u_dut8 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request on the 32-bit port, then scramble inputs after accept
  task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic bi);
    bus32.a        = a;
    bus32.b        = b;
    bus32.ci       = ci;
    bus32.bi       = bi;
    bus32.in_valid = 1'b1;
    check("in_ready_before_accept", 32'(bus32.in_ready), 32'd1);
    tick();
    bus32.in_valid = 1'b0;
    bus32.a        = $urandom;
    bus32.b        = $urandom;
    bus32.ci       = ~ci;
    bus32.bi       = ~bi;
  endtask

  task automatic wait32(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (!bus32.out_valid && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(exp_lat));
  endtask

  task automatic drain32(input string tag);
    bus32.out_ready = 1'b1;
    tick();
    check({tag, "_ov_cleared"}, 32'(bus32.out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(bus32.in_ready), 32'd1);
    bus32.out_ready = 1'b0;
  endtask

  initial begin
    int n;
    n_vec = 0;
    n_err = 0;
    resetn          = 1'b0;
    bus32.in_valid  = 1'b0;
    bus32.a         = '0;
    bus32.b         = '0;
    bus32.ci        = 1'b0;
    bus32.bi        = 1'b0;
    bus32.out_ready = 1'b0;
    bus8.in_valid   = 1'b0;
    bus8.a          = '0;
    bus8.b          = '0;
    bus8.ci         = 1'b0;
    bus8.bi         = 1'b0;
    bus8.out_ready  = 1'b0;

    tick();
    tick();
    check("rst_out_valid", 32'(bus32.out_valid), 32'd0);
    check("rst_y", bus32.y, 32'h0);
    check("rst_x", bus32.x, 32'h0);
    check("rst_co", bus32.co, 32'h0);
    check("rst_in_ready_low", 32'(bus32.in_ready), 32'd0);
    resetn = 1'b1;
    #1;
    check("rst_in_ready_high", 32'(bus32.in_ready), 32'd1);

    // 0xFF + 1: carry across the first segment boundary
    start32(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    check("v1_not_yet_valid", 32'(bus32.out_valid), 32'd0);
    check("v1_in_ready_busy", 32'(bus32.in_ready), 32'd0);
    wait32("v1_latency", 4);
    check("v1_y", bus32.y, 32'h0000_0100);
    check("v1_x", bus32.x, 32'h0000_00FE);
    check("v1_co", bus32.co, 32'h0000_00FF);
    drain32("v1");

    // 5 - 7: borrow
    start32(32'd5, 32'd7, 1'b1, 1'b1);
    wait32("v2_latency", 4);
    check("v2_y", bus32.y, 32'hFFFF_FFFE);
    check("v2_x", bus32.x, 32'hFFFF_FFFD);
    check("v2_co", bus32.co, 32'h0000_0001);
    check("v2_co31", 32'(bus32.co[31]), 32'd0);
    drain32("v2");

    // 0xFFFFFFFF + 0 + 1: carry through every segment
    start32(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    wait32("v3_latency", 4);
    check("v3_y", bus32.y, 32'h0000_0000);
    check("v3_x", bus32.x, 32'hFFFF_FFFF);
    check("v3_co", bus32.co, 32'hFFFF_FFFF);
    drain32("v3");

    // Backpressure: result held while inputs toggle
    start32(32'h0000_000F, 32'h0000_0010, 1'b0, 1'b0);
    wait32("v4_latency", 4);
    for (int i = 0; i < 10; i++) begin
      bus32.in_valid = (i % 2 == 0);
      bus32.a        = $urandom;
      bus32.b        = $urandom;
      tick();
      check("v4_hold_ov", 32'(bus32.out_valid), 32'd1);
      check("v4_hold_y", bus32.y, 32'h0000_001F);
      check("v4_hold_in_ready", 32'(bus32.in_ready), 32'd0);
    end
    bus32.in_valid = 1'b0;
    check("v4_x", bus32.x, 32'h0000_001F);
    check("v4_co", bus32.co, 32'h0000_0000);
    drain32("v4");

    // Reset during RUN at segment 2 aborts the operation
    start32(32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0);
    tick();
    tick();
    resetn = 1'b0;
    tick();
    check("v5_rst_ov", 32'(bus32.out_valid), 32'd0);
    check("v5_rst_y", bus32.y, 32'h0);
    check("v5_rst_x", bus32.x, 32'h0);
    check("v5_rst_co", bus32.co, 32'h0);
    resetn = 1'b1;
    #1;
    check("v5_in_ready_after_rst", 32'(bus32.in_ready), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    check("v5_no_stale_result", 32'(bus32.out_valid), 32'd0);
    start32(32'd3, 32'd4, 1'b0, 1'b0);
    wait32("v5_latency", 4);
    check("v5_y", bus32.y, 32'd7);
    check("v5_x", bus32.x, 32'd7);
    check("v5_co", bus32.co, 32'd0);
    drain32("v5");

    // Request coincident with reset is not accepted
    resetn         = 1'b0;
    bus32.in_valid = 1'b1;
    bus32.a        = 32'd1;
    bus32.b        = 32'd1;
    tick();
    resetn         = 1'b1;
    bus32.in_valid = 1'b0;
    #1;
    check("v7_in_ready", 32'(bus32.in_ready), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    check("v7_no_result", 32'(bus32.out_valid), 32'd0);

    // out_ready with nothing pending is harmless
    bus32.out_ready = 1'b1;
    tick();
    tick();
    check("v8_ov", 32'(bus32.out_valid), 32'd0);
    check("v8_in_ready", 32'(bus32.in_ready), 32'd1);
    bus32.out_ready = 1'b0;

    // Single-segment configuration: 0x80 + 0x80
    bus8.a        = 8'h80;
    bus8.b        = 8'h80;
    bus8.ci       = 1'b0;
    bus8.bi       = 1'b0;
    bus8.in_valid = 1'b1;
    check("v6_in_ready", 32'(bus8.in_ready), 32'd1);
    tick();
    bus8.in_valid = 1'b0;
    bus8.a        = 8'h13;
    bus8.b        = 8'h57;
    n = 0;
    while (!bus8.out_valid && n < 20) begin
      tick();
      n++;
    end
    check("v6_latency", 32'(n), 32'd1);
    check("v6_y", 32'(bus8.y), 32'h00);
    check("v6_x", 32'(bus8.x), 32'h00);
    check("v6_co", 32'(bus8.co), 32'h80);
    bus8.out_ready = 1'b1;
    tick();
    check("v6_ov_cleared", 32'(bus8.out_valid), 32'd0);
    check("v6_in_ready_after", 32'(bus8.in_ready), 32'd1);
    bus8.out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
